tt_um_b14_seq_divider: RTL and testbench

//  Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient + N-bit remainder.

---
 rtl/tt_b14_pkg.sv | 18 +
 rtl/tt_um_b14_seq_divider_div_step.sv | 24 ++
 rtl/tt_um_b14_seq_divider.sv | 109 ++++++++++
 tb/tb_tt_um_b14_seq_divider.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tt_b14_pkg.sv
// Shared types and constants for the sequential restoring divider.
package tt_b14_pkg;
  localparam int N     = 4;           // divisor / quotient / remainder width
  localparam int DIV_W = 2 * N;       // dividend width
  localparam int IDX_W = $clog2(N);   // bit counter width

  // uio pin indices
  localparam int START_BIT = 4;
  localparam int ERR_BIT   = 5;
  localparam int DONE_BIT  = 6;
  localparam int BUSY_BIT  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/tt_um_b14_seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial subtract.
module div_step
  import tt_b14_pkg::*;
(
  input  logic [N:0]   r,
  input  logic         bit_in,
  input  logic [N-1:0] d,
  output logic [N:0]   r_next,
  output logic         q_bit
);
  logic [N:0] t;
  // r[N] is always 0 between steps because the partial remainder stays below D.
  logic       unused_r;

  assign unused_r = r[N];
  assign t        = {r[N-1:0], bit_in};

  // Keep the difference when the trial subtract fits, otherwise restore.
  always_comb begin
    q_bit  = (t >= {1'b0, d});
    r_next = t;
    if (q_bit) r_next = t - {1'b0, d};
  end
endmodule

// File: rtl/tt_um_b14_seq_divider.sv
// Tiny Tapeout top: 8-bit / 4-bit unsigned restoring divider, one bit per clock.
module tt_um_b14_seq_divider
  import tt_b14_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  state_t           state, state_nxt;
  logic             start_r, start_q, start_edge, accept;
  logic             div_zero, ovf;
  logic [N-1:0]     a_lo_q;   // low dividend bits still to be shifted in
  logic [N-1:0]     d_q;
  logic [N:0]       r_q;
  logic [N-1:0]     qw_q;     // quotient under construction
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     quo_q, rem_q;
  logic             err_q;
  logic [N:0]       r_next;
  logic             q_bit;
  logic             unused;

  assign unused = &{ena, uio_in[7:5], 1'b0};

  // Edge is taken between two registered copies of the pin, so the pin never
  // feeds the FSM directly.
  assign start_edge = start_r & ~start_q;
  assign accept     = start_edge & (state != RUN);
  assign div_zero   = (uio_in[N-1:0] == '0);
  assign ovf        = (ui_in[DIV_W-1:N] >= uio_in[N-1:0]);

  div_step u_step (
    .r      (r_q),
    .bit_in (a_lo_q[idx_q]),
    .d      (d_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: errors skip RUN; RUN ends after the step with idx == 0.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = (div_zero || ovf) ? DONE : RUN;
      RUN:        if (idx_q == '0) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Start sync, operand latch, per-step datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_r <= 1'b0;
      start_q <= 1'b0;
      a_lo_q  <= '0;
      d_q     <= '0;
      r_q     <= '0;
      qw_q    <= '0;
      idx_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      start_r <= uio_in[START_BIT];
      start_q <= start_r;
      if (accept) begin
        a_lo_q <= ui_in[N-1:0];
        d_q    <= uio_in[N-1:0];
        r_q    <= {1'b0, ui_in[DIV_W-1:N]};
        idx_q  <= IDX_W'(N - 1);
        qw_q   <= '0;
        err_q  <= 1'b0;
        if (div_zero) begin
          err_q <= 1'b1;
          quo_q <= '1;
          rem_q <= ui_in[N-1:0];
        end else if (ovf) begin
          err_q <= 1'b1;
          quo_q <= '1;
          rem_q <= '1;
        end
      end else if (state == RUN) begin
        r_q         <= r_next;
        qw_q[idx_q] <= q_bit;
        idx_q       <= idx_q - 1'b1;
        // Result only becomes visible on entry to DONE.
        if (idx_q == '0) begin
          quo_q <= {qw_q[N-1:1], q_bit};
          rem_q <= r_next[N-1:0];
        end
      end
    end
  end

  assign uo_out  = {rem_q, quo_q};
  assign uio_out = {(state == RUN), (state == DONE), err_q, 5'b0};
  assign uio_oe  = 8'b1110_0000;
endmodule

// File: tb/tb_tt_um_b14_seq_divider.sv
// Directed bench for the sequential divider.
module tb_tt_um_b14_seq_divider;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_cnt;
  int cyc;

  tt_um_b14_seq_divider dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  wire busy = uio_out[7];
  wire done = uio_out[6];
  wire err  = uio_out[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise start, wait (bounded) for done, check latency and result.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] d,
                         input logic [7:0] exp_uo, input logic exp_err,
                         input int exp_lat, input bit hold);
    ui_in  = a;
    uio_in = {3'b000, 1'b1, d};
    cyc = 0;
    busy_cnt = 0;
    do begin
      tick();
      cyc++;
      if (busy) busy_cnt++;
    end while ((cyc < 2 || !done) && cyc < 20);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " result"}, uo_out, exp_uo);
    check({tag, " err"}, err, exp_err);
    if (!hold) begin
      uio_in[4] = 1'b0;
      tick(); tick(); tick();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    tick(); tick();
    check("reset uo_out", uo_out, 8'h00);
    check("reset uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'hE0);
    rst_n = 1'b1;
    tick();
    check("idle uio_out", uio_out, 8'h00);

    // 195/13 = 15 r 0
    run_div("195/13", 8'hC3, 4'hD, 8'h0F, 1'b0, 6, 1'b0);
    check("195/13 busy cycles", busy_cnt, 4);
    check("done held after start drop", done, 1'b1);

    // 100/7 = 14 r 2
    run_div("100/7", 8'h64, 4'h7, 8'h2E, 1'b0, 6, 1'b0);
    check("100/7 busy cycles", busy_cnt, 4);

    // divide by zero
    run_div("div0", 8'h5A, 4'h0, 8'hAF, 1'b1, 2, 1'b0);
    check("div0 busy cycles", busy_cnt, 0);
    // overflow
    run_div("ovf", 8'h80, 4'h5, 8'hFF, 1'b1, 2, 1'b0);
    // non-error divide clears err: 15/15 = 1 r 0, boundary A[7:4]=0
    run_div("15/15", 8'h0F, 4'hF, 8'h01, 1'b0, 6, 1'b0);
    // largest non-overflow: 239/15 = 15 r 14
    run_div("239/15", 8'hEF, 4'hF, 8'hEF, 1'b0, 6, 1'b0);

    // Round trip m*q / q
    for (int m = 1; m < 16; m++) begin
      for (int q = 1; q < 16; q++) begin
        logic [7:0] a;
        logic [7:0] e;
        a = 8'(m * q);
        e = {4'h0, 4'(m)};
        run_div($sformatf("rt %0d*%0d", m, q), a, 4'(q), e, 1'b0, 6, 1'b0);
      end
    end

    // Start held high across DONE: no restart
    run_div("hold", 8'h64, 4'h7, 8'h2E, 1'b0, 6, 1'b1);
    ui_in = 8'hC3;
    uio_in[3:0] = 4'hD;
    for (int k = 0; k < 8; k++) tick();
    check("hold done", done, 1'b1);
    check("hold busy", busy, 1'b0);
    check("hold result", uo_out, 8'h2E);
    uio_in[4] = 1'b0;
    tick(); tick(); tick();

    // Start edge during RUN is ignored; operand pin changes ignored too
    ui_in  = 8'hC3;
    uio_in = 8'h1D;
    tick(); tick(); tick();
    check("run busy", busy, 1'b1);
    uio_in[4] = 1'b0;
    ui_in = 8'h64;
    uio_in[3:0] = 4'h7;
    tick();
    uio_in[4] = 1'b1;
    tick(); tick();
    check("run edge done", done, 1'b1);
    check("run edge result", uo_out, 8'h0F);
    tick(); tick(); tick();
    check("run edge no restart", busy, 1'b0);
    check("run edge result stable", uo_out, 8'h0F);
    uio_in[4] = 1'b0;
    tick(); tick(); tick();

    // Reset on the second RUN cycle aborts the divide
    ui_in  = 8'h64;
    uio_in = 8'h17;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort uo_out", uo_out, 8'h00);
    uio_in[4] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_div("after reset", 8'hC3, 4'hD, 8'h0F, 1'b0, 6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
